// File: rtl/parking_pkg.sv
// Shared types and constants for the parking fee unit and its time base.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } fee_state_t;

  localparam logic [1:0]  ID_NONE   = 2'd0;
  localparam logic [1:0]  ID_MAX    = 2'd3;
  localparam int unsigned NUM_SLOTS = 3;

endpackage

// File: rtl/parking_time_base.sv
// Free-running time base: prescaler of TICK_DIV clocks feeding a wrapping time counter.
module parking_time_base #(
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned TS_W     = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic [TS_W-1:0] time_now
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);

    logic [PRE_W-1:0] presc;
    logic             wrap;

    always_comb begin
        wrap = (presc == PRE_W'(TICK_DIV - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc    <= '0;
            time_now <= '0;
        end else if (wrap) begin
            presc    <= '0;
            time_now <= time_now + TS_W'(1);
        end else begin
            presc    <= presc + PRE_W'(1);
        end
    end

endmodule

// File: rtl/parking_fee_unit.sv
// Per-slot entry stamping and exit fee calculation for the garage controller.
module parking_fee_unit
    import parking_pkg::*;
#(
    parameter int unsigned TS_W     = 16,
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned RATE     = 5,
    parameter int unsigned COST_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              buffer_write,
    input  logic              buffer_read,
    input  logic [1:0]        id,
    output logic [TS_W-1:0]   time_now,
    output logic [2:0]        occupied,
    output logic [TS_W-1:0]   duration,
    output logic [COST_W-1:0] cost,
    output logic              cost_valid,
    output logic              err_no_entry,
    output logic              err_dup_entry,
    output logic              err_busy
);

    localparam int unsigned      PROD_W   = TS_W + 32;
    localparam logic [PROD_W-1:0] COST_MAX = PROD_W'({COST_W{1'b1}});

    fee_state_t      state, state_next;
    logic            idle, calc_en;
    logic            wr_q, rd_q;
    logic            wr_evt, rd_evt, id_valid;
    logic            sel_occ;
    logic [TS_W-1:0] sel_stamp;
    logic            exit_ok, exit_none, exit_busy, entry_ok, entry_dup;
    logic [TS_W-1:0] stamp [NUM_SLOTS];
    logic [TS_W-1:0] charged;
    logic [PROD_W-1:0] product;

    parking_time_base #(
        .TICK_DIV(TICK_DIV),
        .TS_W    (TS_W)
    ) u_time_base (
        .clk     (clk),
        .reset_n (reset_n),
        .time_now(time_now)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (exit_ok) state_next = CALC;
            CALC:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        idle    = (state == IDLE);
        calc_en = (state == CALC);
    end

    always_comb begin
        wr_evt    = buffer_write & ~wr_q;
        rd_evt    = buffer_read & ~rd_q;
        id_valid  = (id != ID_NONE) && (int'(id) <= int'(ID_MAX));
        sel_occ   = 1'b0;
        sel_stamp = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            if (id == 2'(k + 1)) begin
                sel_occ   = occupied[k];
                sel_stamp = stamp[k];
            end
        end
        exit_ok   = rd_evt & id_valid & idle & sel_occ;
        exit_none = rd_evt & id_valid & idle & ~sel_occ;
        exit_busy = rd_evt & id_valid & ~idle;
        // The exit is resolved first, so a same-edge re-entry sees the slot as free.
        entry_ok  = wr_evt & id_valid & (~sel_occ | exit_ok);
        entry_dup = wr_evt & id_valid & sel_occ & ~exit_ok;
    end

    always_comb begin
        charged = (duration == '0) ? TS_W'(1) : duration;
        product = PROD_W'(charged) * PROD_W'(RATE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q          <= 1'b0;
            rd_q          <= 1'b0;
            occupied      <= '0;
            duration      <= '0;
            cost          <= '0;
            cost_valid    <= 1'b0;
            err_no_entry  <= 1'b0;
            err_dup_entry <= 1'b0;
            err_busy      <= 1'b0;
            for (int unsigned k = 0; k < NUM_SLOTS; k++) stamp[k] <= '0;
        end else begin
            wr_q          <= buffer_write;
            rd_q          <= buffer_read;
            cost_valid    <= calc_en;
            err_no_entry  <= exit_none;
            err_dup_entry <= entry_dup;
            err_busy      <= exit_busy;
            if (exit_ok) duration <= time_now - sel_stamp;
            if (calc_en) cost <= (product > COST_MAX) ? '1 : COST_W'(product);
            for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
                if (id == 2'(k + 1)) begin
                    if (entry_ok) begin
                        occupied[k] <= 1'b1;
                        stamp[k]    <= time_now;
                    end else if (exit_ok) begin
                        occupied[k] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_parking_fee_unit.sv
// Directed plus random stimulus for parking_fee_unit against a cycle-indexed reference model.
module tb_parking_fee_unit;

    localparam int unsigned TS_W     = 8;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned RATE     = 5;
    localparam int unsigned COST_W   = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              buffer_write = 1'b0;
    logic              buffer_read = 1'b0;
    logic [1:0]        id = 2'd0;
    logic [TS_W-1:0]   time_now;
    logic [2:0]        occupied;
    logic [TS_W-1:0]   duration;
    logic [COST_W-1:0] cost;
    logic              cost_valid;
    logic              err_no_entry;
    logic              err_dup_entry;
    logic              err_busy;

    int compared   = 0;
    int mismatched = 0;
    int cv_count   = 0;

    // Reference model state: edges counted since reset release
    int edges;
    bit pw, pr;
    bit occ[4];
    int stamp[4];
    int last_exit;
    int m_dur, m_cost, pend_cost;
    bit m_cv, m_no, m_dup, m_busy;

    always #5 clk = ~clk;

    parking_fee_unit #(
        .TS_W    (TS_W),
        .TICK_DIV(TICK_DIV),
        .RATE    (RATE),
        .COST_W  (COST_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .buffer_write (buffer_write),
        .buffer_read  (buffer_read),
        .id           (id),
        .time_now     (time_now),
        .occupied     (occupied),
        .duration     (duration),
        .cost         (cost),
        .cost_valid   (cost_valid),
        .err_no_entry (err_no_entry),
        .err_dup_entry(err_dup_entry),
        .err_busy     (err_busy)
    );

    function automatic int t_pre();
        return (edges / TICK_DIV) % 256;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("time_now",      32'(time_now),      32'(t_pre()));
        check("occupied",      32'(occupied),      32'({occ[3], occ[2], occ[1]}));
        check("duration",      32'(duration),      32'(m_dur));
        check("cost",          32'(cost),          32'(m_cost));
        check("cost_valid",    32'(cost_valid),    32'(m_cv));
        check("err_no_entry",  32'(err_no_entry),  32'(m_no));
        check("err_dup_entry", 32'(err_dup_entry), 32'(m_dup));
        check("err_busy",      32'(err_busy),      32'(m_busy));
        if (cost_valid === 1'b1) cv_count++;
    endtask

    task automatic model_reset();
        edges = 0; pw = 0; pr = 0;
        for (int k = 0; k < 4; k++) begin occ[k] = 0; stamp[k] = 0; end
        last_exit = -100;
        m_dur = 0; m_cost = 0; pend_cost = 0;
        m_cv = 0; m_no = 0; m_dup = 0; m_busy = 0;
    endtask

    // Called at a negedge: apply inputs, predict the coming edge, check after it.
    task automatic step(input bit w, input bit r, input logic [1:0] i);
        bit we, re;
        int tnow, d;
        buffer_write = w; buffer_read = r; id = i;
        we = w && !pw; re = r && !pr; pw = w; pr = r;
        tnow = t_pre();
        m_no = 0; m_dup = 0; m_busy = 0;
        m_cv = (edges == last_exit + 1);
        if (m_cv) m_cost = pend_cost;
        if (i != 0) begin
            if (re) begin
                if (edges < last_exit + 3) m_busy = 1;
                else if (!occ[i]) m_no = 1;
                else begin
                    occ[i] = 0;
                    m_dur = (tnow - stamp[i] + 256) % 256;
                    d = (m_dur == 0) ? 1 : m_dur;
                    pend_cost = (d * RATE > 255) ? 255 : d * RATE;
                    last_exit = edges;
                end
            end
            if (we) begin
                if (occ[i]) m_dup = 1;
                else begin occ[i] = 1; stamp[i] = tnow; end
            end
        end
        edges++;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_time(input int t);
        int guard = 0;
        while (!(t_pre() == t && edges % TICK_DIV == 0) && guard < 3000) begin
            step(0, 0, 0);
            guard++;
        end
    endtask

    initial begin
        logic [2:0] occ_saved;
        model_reset();
        @(negedge clk);
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Normal exit: stamp 3, exit at 10
        wait_time(3);
        step(1, 0, 2'd1);
        wait_time(10);
        step(0, 1, 2'd1);
        check("s1_duration", 32'(duration), 32'd7);
        check("s1_occupied", 32'(occupied), 32'd0);
        step(0, 0, 2'd0);
        check("s1_cost", 32'(cost), 32'd35);
        check("s1_cost_valid", 32'(cost_valid), 32'd1);
        step(0, 0, 2'd0);
        check("s1_cost_valid_drop", 32'(cost_valid), 32'd0);

        // Minimum charge: entry and exit in the same time unit
        wait_time(12);
        step(1, 0, 2'd2);
        step(0, 0, 2'd2);
        step(0, 1, 2'd2);
        check("s2_duration", 32'(duration), 32'd0);
        step(0, 0, 2'd0);
        check("s2_cost", 32'(cost), 32'd5);

        // Wrap-around, same-edge re-entry, then saturation
        wait_time(250);
        step(1, 0, 2'd3);
        wait_time(4);
        step(1, 1, 2'd3);
        check("s3_duration", 32'(duration), 32'd10);
        check("s3_reentry_occ", 32'(occupied), 32'b100);
        check("s3_no_dup", 32'(err_dup_entry), 32'd0);
        step(0, 0, 2'd0);
        check("s3_cost", 32'(cost), 32'd50);
        wait_time(64);
        step(0, 1, 2'd3);
        check("s3_duration_sat", 32'(duration), 32'd60);
        step(0, 0, 2'd0);
        check("s3_cost_sat", 32'(cost), 32'd255);

        // Error paths
        step(0, 0, 2'd0);
        step(0, 1, 2'd2);
        check("s4_no_entry", 32'(err_no_entry), 32'd1);
        step(0, 0, 2'd0);
        check("s4_no_entry_cv", 32'(cost_valid), 32'd0);
        wait_time(70);
        step(1, 0, 2'd1);
        step(0, 0, 2'd0);
        step(1, 0, 2'd1);
        check("s4_dup_entry", 32'(err_dup_entry), 32'd1);
        step(0, 0, 2'd0);
        step(1, 0, 2'd3);
        wait_time(75);
        step(0, 1, 2'd1);
        check("s4_stamp_kept", 32'(duration), 32'd5);
        step(0, 0, 2'd0);
        step(0, 1, 2'd3);
        check("s4_busy", 32'(err_busy), 32'd1);
        check("s4_busy_occ", 32'(occupied), 32'b100);
        step(0, 0, 2'd0);

        // Held strobe gives exactly one result; id 0 is ignored
        step(1, 0, 2'd1);
        step(0, 0, 2'd0);
        cv_count = 0;
        repeat (6) step(0, 1, 2'd1);
        repeat (3) step(0, 0, 2'd0);
        check("s5_single_pulse", 32'(cv_count), 32'd1);
        occ_saved = occupied;
        step(1, 1, 2'd0);
        check("s5_id0_occ", 32'(occupied), 32'(occ_saved));
        check("s5_id0_err", 32'({err_no_entry, err_dup_entry, err_busy}), 32'd0);
        step(0, 0, 2'd0);

        // Reset while in CALC
        step(1, 0, 2'd2);
        step(0, 0, 2'd0);
        step(0, 1, 2'd2);
        reset_n = 1'b0;
        buffer_write = 1'b0; buffer_read = 1'b0; id = 2'd0;
        model_reset();
        #1;
        check_all();
        repeat (3) @(negedge clk);
        check_all();
        reset_n = 1'b1;
        step(0, 0, 2'd0);
        check("s6_cv_after_reset", 32'(cost_valid), 32'd0);
        check("s6_time_zero", 32'(time_now), 32'd0);
        check("s6_occupied", 32'(occupied), 32'd0);
        step(0, 0, 2'd0);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            step(($urandom % 3) == 0, ($urandom % 3) == 0, 2'($urandom % 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
